// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard beside ID: tracks DEPTH in-flight writers, stalls/bubbles ID, freezes on a slow MEM load.
// hazard/bubble/freeze are combinational from the entries; freeze overrides stalls and holds all tracked state.
module hazard_scoreboard #(
    parameter int REG_AW   = 4,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fwd_en,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_use,
    input  logic [REG_AW-1:0]         id_dest,
    input  logic                      id_wb_en,
    input  logic                      id_mem_r_en,
    input  logic                      flush,
    input  logic                      mem_ready,
    output logic                      hazard,
    output logic                      bubble,
    output logic                      freeze,
    output logic [15:0]               stall_count,
    output logic                      mem_timeout
);

    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam logic TIMEOUT_ON_ENTRY = (MAX_WAIT <= 1);

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] dest;
        logic              wb;
        logic              rd;
    } entry_t;

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    entry_t         ent [DEPTH];
    state_t         state;
    logic [WCW-1:0] wait_cnt;
    logic           raw;

    // With forwarding only a load still in EXE cannot be bypassed in time.
    always_comb begin
        raw = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (id_valid && id_src_use[k]) begin
                if (fwd_en) begin
                    if (ent[0].v && ent[0].rd && (ent[0].dest == id_src[k*REG_AW +: REG_AW]))
                        raw = 1'b1;
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (ent[i].v && ent[i].wb && (ent[i].dest == id_src[k*REG_AW +: REG_AW]))
                            raw = 1'b1;
                    end
                end
            end
        end
    end

    assign freeze = ent[1].v & ent[1].rd & ~mem_ready;
    assign hazard = raw & ~freeze & ~flush;
    assign bubble = (hazard | flush) & ~freeze;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else if (!freeze) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                ent[i] <= ent[i-1];
            end
            if (bubble) begin
                ent[0] <= '0;
            end else begin
                ent[0].v    <= id_valid;
                ent[0].dest <= id_dest;
                ent[0].wb   <= id_wb_en & id_valid;
                ent[0].rd   <= id_mem_r_en & id_valid;
            end
        end
    end

    // The wait counter is bookkeeping only; freeze itself always follows mem_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (freeze) begin
                        state       <= MEM_WAIT;
                        wait_cnt    <= WCW'(1);
                        mem_timeout <= mem_timeout | TIMEOUT_ON_ENTRY;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else begin
                        if (wait_cnt < WCW'(MAX_WAIT))
                            wait_cnt <= wait_cnt + WCW'(1);
                        if (wait_cnt >= WCW'(MAX_WAIT - 1))
                            mem_timeout <= 1'b1;
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if ((hazard || freeze) && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (REG_AW=4, NUM_SRC=2, DEPTH=2, MAX_WAIT=4).
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        fwd_en;
    logic        id_valid;
    logic [7:0]  id_src;
    logic [1:0]  id_src_use;
    logic [3:0]  id_dest;
    logic        id_wb_en;
    logic        id_mem_r_en;
    logic        flush;
    logic        mem_ready;
    logic        hazard;
    logic        bubble;
    logic        freeze;
    logic [15:0] stall_count;
    logic        mem_timeout;

    int total = 0;
    int bad   = 0;

    hazard_scoreboard #(
        .REG_AW  (4),
        .NUM_SRC (2),
        .DEPTH   (2),
        .MAX_WAIT(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fwd_en     (fwd_en),
        .id_valid   (id_valid),
        .id_src     (id_src),
        .id_src_use (id_src_use),
        .id_dest    (id_dest),
        .id_wb_en   (id_wb_en),
        .id_mem_r_en(id_mem_r_en),
        .flush      (flush),
        .mem_ready  (mem_ready),
        .hazard     (hazard),
        .bubble     (bubble),
        .freeze     (freeze),
        .stall_count(stall_count),
        .mem_timeout(mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [1:0] u, input logic [3:0] d, input logic wb, input logic rd);
        id_valid    = v;
        id_src      = {s1, s0};
        id_src_use  = u;
        id_dest     = d;
        id_wb_en    = wb;
        id_mem_r_en = rd;
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic h, input logic b, input logic f);
        chk({tag, "_hazard"}, {31'd0, hazard}, {31'd0, h});
        chk({tag, "_bubble"}, {31'd0, bubble}, {31'd0, b});
        chk({tag, "_freeze"}, {31'd0, freeze}, {31'd0, f});
    endtask

    initial begin
        // Reset held two edges with an ID instruction that would self-match.
        rst_n     = 1'b0;
        fwd_en    = 1'b0;
        flush     = 1'b0;
        mem_ready = 1'b0;
        drv(1'b1, 4'd5, 4'd5, 2'b11, 4'd5, 1'b1, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        outs("reset", 1'b0, 1'b0, 1'b0);
        chk("reset_stall", {16'd0, stall_count}, 32'd0);
        chk("reset_timeout", {31'd0, mem_timeout}, 32'd0);
        fwd_en    = 1'b1;
        mem_ready = 1'b1;
        idle();
        tick();

        // Load-use with forwarding: LDR R3 then ADD R1,R3,R2.
        drv(1'b1, 4'd0, 4'd0, 2'b00, 4'd3, 1'b1, 1'b1);
        outs("ldr_issue", 1'b0, 1'b0, 1'b0);
        tick();
        drv(1'b1, 4'd3, 4'd2, 2'b11, 4'd1, 1'b1, 1'b0);
        outs("ldu_stall", 1'b1, 1'b1, 1'b0);
        tick();
        outs("ldu_issue", 1'b0, 1'b0, 1'b0);
        chk("ldu_stall_count", {16'd0, stall_count}, 32'd1);
        tick();
        idle();
        tick();
        tick();

        // No forwarding: dependency through operand 1 only.
        fwd_en = 1'b0;
        drv(1'b1, 4'd0, 4'd0, 2'b00, 4'd4, 1'b1, 1'b0);
        tick();
        drv(1'b1, 4'd7, 4'd4, 2'b10, 4'd5, 1'b1, 1'b0);
        outs("nofwd_c1", 1'b1, 1'b1, 1'b0);
        tick();
        outs("nofwd_c2", 1'b1, 1'b1, 1'b0);
        tick();
        outs("nofwd_c3", 1'b0, 1'b0, 1'b0);
        chk("nofwd_stall_count", {16'd0, stall_count}, 32'd3);
        tick();
        idle();
        tick();
        tick();

        // Same pair but operand 1 not read.
        drv(1'b1, 4'd0, 4'd0, 2'b00, 4'd4, 1'b1, 1'b0);
        tick();
        drv(1'b1, 4'd7, 4'd4, 2'b01, 4'd5, 1'b1, 1'b0);
        outs("nouse", 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        tick();

        // Highest register number is compared like any other.
        drv(1'b1, 4'd0, 4'd0, 2'b00, 4'd15, 1'b1, 1'b0);
        tick();
        drv(1'b1, 4'd15, 4'd0, 2'b01, 4'd1, 1'b1, 1'b0);
        outs("r15_c1", 1'b1, 1'b1, 1'b0);
        tick();
        outs("r15_c2", 1'b1, 1'b1, 1'b0);
        tick();
        outs("r15_c3", 1'b0, 1'b0, 1'b0);
        chk("r15_stall_count", {16'd0, stall_count}, 32'd5);
        tick();
        idle();
        tick();
        tick();

        // Flush beats a load-use hazard and leaves entry0 empty.
        fwd_en = 1'b1;
        drv(1'b1, 4'd0, 4'd0, 2'b00, 4'd6, 1'b1, 1'b1);
        tick();
        flush = 1'b1;
        drv(1'b1, 4'd6, 4'd0, 2'b01, 4'd2, 1'b1, 1'b0);
        outs("flush", 1'b0, 1'b1, 1'b0);
        tick();
        flush = 1'b0;
        #1;
        outs("post_flush", 1'b0, 1'b0, 1'b0);
        chk("flush_stall_count", {16'd0, stall_count}, 32'd5);
        tick();
        idle();
        tick();
        tick();

        // Multi-cycle load in MEM: five wait cycles, timeout after the fourth.
        drv(1'b1, 4'd0, 4'd0, 2'b00, 4'd8, 1'b1, 1'b1);
        tick();
        drv(1'b1, 4'd2, 4'd0, 2'b01, 4'd9, 1'b1, 1'b0);
        outs("pre_mem", 1'b0, 1'b0, 1'b0);
        tick();
        mem_ready = 1'b0;
        drv(1'b1, 4'd8, 4'd0, 2'b01, 4'd3, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            flush = (i == 3);
            #1;
            outs($sformatf("memwait%0d", i), 1'b0, 1'b0, 1'b1);
            chk($sformatf("memwait%0d_timeout", i), {31'd0, mem_timeout}, {31'd0, (i == 5)});
            tick();
        end
        flush     = 1'b0;
        mem_ready = 1'b1;
        idle();
        outs("mem_release", 1'b0, 1'b0, 1'b0);
        chk("mem_stall_count", {16'd0, stall_count}, 32'd10);
        chk("mem_timeout_held", {31'd0, mem_timeout}, 32'd1);
        tick();
        // ADD R9 was held during the freeze and now sits in entry1.
        fwd_en    = 1'b0;
        mem_ready = 1'b0;
        drv(1'b1, 4'd9, 4'd0, 2'b01, 4'd1, 1'b1, 1'b0);
        outs("after_release", 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        mem_ready = 1'b1;
        fwd_en    = 1'b1;
        tick();
        tick();
        chk("final_stall_count", {16'd0, stall_count}, 32'd11);
        chk("timeout_sticky", {31'd0, mem_timeout}, 32'd1);

        // Reset in the middle of a memory wait.
        drv(1'b1, 4'd0, 4'd0, 2'b00, 4'd10, 1'b1, 1'b1);
        tick();
        idle();
        tick();
        mem_ready = 1'b0;
        #1;
        outs("mw_before_reset", 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        outs("mw_after_reset", 1'b0, 1'b0, 1'b0);
        chk("mw_reset_stall", {16'd0, stall_count}, 32'd0);
        chk("mw_reset_timeout", {31'd0, mem_timeout}, 32'd0);
        chk("mw_reset_waitcnt", {29'd0, dut.wait_cnt}, 32'd0);
        tick();
        outs("mw_after_reset2", 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

- Parametrised successor to the ID-stage hazard detector, sitting beside the ID stage of the ARM pipeline.
- Instead of taking EXE/MEM destinations as inputs, it keeps its own shift register of in-flight writers over DEPTH stages past ID.
- It detects RAW hazards for NUM_SRC source operands, with or without forwarding.
- It freezes the whole pipeline while a load in MEM waits on a multi-cycle data memory, and counts stall cycles and memory-wait timeouts.

## Interface
- REG_AW, 4, register address width
- NUM_SRC, 2, source operands checked per ID instruction
- DEPTH, 2, tracked stages after ID; entry 0 = EXE, entry 1 = MEM, ... (DEPTH ≥ 2)
- MAX_WAIT, 64, MEM_WAIT cycles before mem_timeout is raised
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- fwd_en  in  1  forwarding unit enabled
- id_valid  in  1  ID holds a real instruction
- id_src  in  NUM_SRC*REG_AW  source register numbers; operand k at bits [k*REG_AW +: REG_AW]
- id_src_use  in  NUM_SRC  operand k is actually read
- id_dest  in  REG_AW  destination of ID instruction
- id_wb_en  in  1  ID instruction writes the register file
- id_mem_r_en  in  1  ID instruction is a load
- flush  in  1  taken branch resolved in EXE; kill the ID instruction
- mem_ready  in  1  data memory completes the access this cycle
- hazard  out  1  stall PC and IF/ID
- bubble  out  1  load NOP into ID/EXE
- freeze  out  1  hold every pipeline register
- stall_count  out  16  saturating count of cycles with hazard or freeze high
- mem_timeout  out  1  sticky: one MEM wait exceeded MAX_WAIT

## Operation
Tracking entries:
- Each entry holds {v, dest, wb, rd}.

Hazard, evaluated combinationally from the entries and the ID inputs:
- For each operand k with id_valid & id_src_use[k]:
  - fwd_en=1: match if entry0.v & entry0.rd & entry0.dest==src_k. Load-use only.
  - fwd_en=0: match if any entry i has v & wb & dest==src_k.
- hazard = OR of all matches, masked by !freeze & !flush.
- bubble = hazard | flush, masked by !freeze.

Freeze:
- freeze = entry1.v & entry1.rd & !mem_ready.
- While freeze=1: hazard=0, bubble=0, and flush is ignored. Upstream holds flush until the freeze releases.

Entry update on every clock where !freeze:
- Entries shift up; entry DEPTH-1 is discarded.
- If bubble=1, entry0 gets v=0.
- Otherwise entry0 gets {id_valid, id_dest, id_wb_en & id_valid, id_mem_r_en & id_valid}.
- With freeze=1 all entries hold.

FSM, two states:
- RUN:
  - freeze=1 → MEM_WAIT, wait_cnt ← 1.
- MEM_WAIT:
  - mem_ready=1 → RUN, wait_cnt ← 0.
  - Otherwise wait_cnt increments, saturating at MAX_WAIT.
  - When wait_cnt reaches MAX_WAIT, mem_timeout ← 1 (sticky). The wait continues and freeze is still driven by mem_ready.
- wait_cnt is ⌈log2(MAX_WAIT+1)⌉ bits.

stall_count:
- +1 on each clock where hazard | freeze.
- Saturates at 16'hFFFF.

## Timing
Reset (rst_n=0 at an edge):
- All entries v=0, state RUN, wait_cnt=0, stall_count=0, mem_timeout=0.
- The next cycle, hazard=bubble=freeze=0 regardless of ID inputs.

Load-use with fwd_en=1:
- Exactly one hazard cycle.
- At the next edge the load moves to entry1, the bubble sits in entry0, and the dependent instruction issues.

fwd_en=0:
- A dependency on entry0 stalls DEPTH cycles; one on entry i stalls DEPTH-i cycles.

Flush:
- flush and hazard in the same cycle: flush wins, hazard=0, bubble=1.

Memory wait:
- A load reaching MEM with mem_ready=0 raises freeze in that same cycle.
- Freeze drops combinationally in the cycle mem_ready=1, and the entries shift at that edge.

Reset mid-MEM_WAIT:
- Returns to RUN and clears entries. freeze=0 the next cycle even if mem_ready=0.

Register 0 is not special; every register number, including 15, is compared.

## Test plan
- Reset: rst_n=0 for 2 cycles with id_valid=1 and src=dest patterns → hazard=bubble=freeze=0, stall_count=0, mem_timeout=0.
- fwd_en=1: LDR R3 issued, then ADD R1,R3,R2 (src0=3) → hazard=1 for exactly 1 cycle, bubble=1, stall_count=1; the ADD issues the following cycle.
- fwd_en=0: ADD R4 issued, then SUB using src1=4 with id_src_use=2'b10 → hazard for 2 cycles. The same with id_src_use=2'b01 → no hazard.
- Flush: load in entry0, dependent ID instruction, flush=1 together → hazard=0, bubble=1, entry0 invalid next cycle, no stall the cycle after.
- Memory wait: load in MEM, mem_ready=0 for 5 cycles → freeze=1 for 5 cycles, hazard=0 throughout, entries unchanged, stall_count=5. Release with mem_ready=1 → resumes. With MAX_WAIT=4 → mem_timeout=1 after the 4th wait cycle and it stays 1.
- Reset while in MEM_WAIT with mem_ready=0 → freeze=0 the next cycle, state RUN.
